// File: rtl/shift_right_seq_if.sv
// Handshake and data bundle for shift_right_seq.
// The master drives the request side; the slave (the shifter) returns the result and status.
interface shift_right_seq_if #(
  parameter int WIDTH   = 13,
  parameter int SHAMT_W = 4
);
  logic               start;
  logic               arith;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   in13;
  logic [WIDTH-1:0]   out12;
  logic               busy;
  logic               done;
  logic               sticky;

  modport master (
    output start, arith, shamt, in13,
    input  out12, busy, done, sticky
  );

  modport slave (
    input  start, arith, shamt, in13,
    output out12, busy, done, sticky
  );
endinterface

// File: rtl/shift_right_seq.sv
// Sequential right shifter: one bit per clock, logical or arithmetic, start/busy/done handshake.
// Optional macro SHIFT_STICKY_EN adds a sticky register (OR of every bit shifted out).
module shift_right_seq #(
  parameter int WIDTH   = 13,
  parameter int SHAMT_W = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  shift_right_seq_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_data;
  logic [CNT_W-1:0] r_count;
  logic             r_arith;
  logic [CNT_W-1:0] w_loadCount;
  logic             w_fill;
  logic             w_shiftNow;

  // Amounts of WIDTH or more all produce the fully shifted-out result.
  always_comb begin
    w_loadCount = CNT_W'(WIDTH);
    if (int'(bus.shamt) < WIDTH) begin
      w_loadCount = CNT_W'(bus.shamt);
    end
  end

  assign w_fill     = r_arith & r_data[WIDTH-1];
  assign w_shiftNow = (r_state == S_SHIFT) && (r_count != '0);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_data  <= '0;
      r_count <= '0;
      r_arith <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_data  <= bus.in13;
            r_arith <= bus.arith;
            r_count <= w_loadCount;
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (r_count != '0) begin
            r_data  <= {w_fill, r_data[WIDTH-1:1]};
            r_count <= r_count - 1'b1;
          end else begin
            r_state <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef SHIFT_STICKY_EN
  logic r_sticky;

  // Collects the bit about to fall off the bottom; cleared only by a newly accepted start.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sticky <= 1'b0;
    end else if ((r_state == S_IDLE) && bus.start) begin
      r_sticky <= 1'b0;
    end else if (w_shiftNow) begin
      r_sticky <= r_sticky | r_data[0];
    end
  end

  assign bus.sticky = r_sticky;
`else
  assign bus.sticky = 1'b0;
`endif

  assign bus.out12 = r_data;
  assign bus.busy  = (r_state == S_SHIFT);
  assign bus.done  = (r_state == S_DONE);
endmodule

// File: tb/tb_shift_right_seq.sv
// Testbench for shift_right_seq: directed plan vectors plus randomized operations
// checked against an arithmetic reference model of the right shift.
module tb_shift_right_seq;
  localparam int WIDTH   = 13;
  localparam int SHAMT_W = 4;

  logic clk;
  logic reset_n;
  int   nCompared;
  int   nMismatched;

  shift_right_seq_if #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) bus ();

  shift_right_seq #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int effAmount(input logic [3:0] sh);
    return (int'(sh) > WIDTH) ? WIDTH : int'(sh);
  endfunction

  function automatic logic [12:0] refOut(input logic [12:0] v, input logic [3:0] sh, input bit ar);
    int k;
    k = effAmount(sh);
    if (ar) return 13'($signed(v) >>> k);
    return v >> k;
  endfunction

  function automatic logic refSticky(input logic [12:0] v, input logic [3:0] sh);
    int k;
    logic [31:0] mask;
    k = effAmount(sh);
    mask = (32'h1 << k) - 32'h1;
`ifdef SHIFT_STICKY_EN
    return ((32'(v) & mask) != 32'h0);
`else
    return (mask == 32'hFFFF_FFFF);
`endif
  endfunction

  // Starts one operation from IDLE and follows it until done (or a 40-cycle bound).
  task automatic runOp(input logic [12:0] v, input logic [3:0] sh, input bit ar, input bit holdStart,
                       output logic [12:0] resOut, output logic resSticky, output int latency,
                       output int busyCycles, output bit busyBeforeDone);
    bus.in13 = v; bus.shamt = sh; bus.arith = ar; bus.start = 1'b1;
    @(posedge clk); #1;
    if (!holdStart) bus.start = 1'b0;
    latency = -1; busyCycles = 0; busyBeforeDone = 1'b0;
    for (int n = 0; n < 40; n++) begin
      bus.in13 = 13'($urandom); bus.shamt = 4'($urandom); bus.arith = 1'($urandom);
      if (bus.done) begin latency = n; break; end
      busyBeforeDone = bus.busy;
      if (bus.busy) busyCycles++;
      @(posedge clk); #1;
    end
    resOut = bus.out12; resSticky = bus.sticky;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; bus.start = 1'b1; bus.in13 = 13'h1ABC; bus.shamt = 4'd3; bus.arith = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    nCompared++;
    if ({bus.out12, bus.busy, bus.done, bus.sticky} !== 16'h0) begin
      nMismatched++;
      $display("[TB] FAIL reset_state: got out=%h busy=%b done=%b sticky=%b, expected all zero",
               bus.out12, bus.busy, bus.done, bus.sticky);
    end
    bus.start = 1'b0;
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_plan_vectors();
    logic [12:0] vIn [6] = '{13'b1111000011000, 13'b1111000011000, 13'h0AAA, 13'h1FFF, 13'h1000, 13'h1001};
    logic [3:0]  vSh [6] = '{4'd1, 4'd4, 4'd0, 4'd15, 4'd15, 4'd13};
    bit          vAr [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [12:0] o; logic s; int lat; int bc; bit bbd; logic [12:0] eo; logic es; int k;
    for (int i = 0; i < 6; i++) begin
      runOp(vIn[i], vSh[i], vAr[i], 1'b0, o, s, lat, bc, bbd);
      eo = refOut(vIn[i], vSh[i], vAr[i]); es = refSticky(vIn[i], vSh[i]); k = effAmount(vSh[i]);
      nCompared++;
      if (o !== eo || s !== es) begin
        nMismatched++;
        $display("[TB] FAIL plan_result[%0d]: got out=%b sticky=%b, expected out=%b sticky=%b", i, o, s, eo, es);
      end
      nCompared++;
      if (lat !== k + 1 || bc !== k + 1 || bbd !== 1'b1) begin
        nMismatched++;
        $display("[TB] FAIL plan_timing[%0d]: got latency=%0d busy=%0d busyBeforeDone=%b, expected %0d/%0d/1",
                 i, lat, bc, bbd, k + 1, k + 1);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random();
    logic [12:0] v; logic [3:0] sh; bit ar;
    logic [12:0] o; logic s; int lat; int bc; bit bbd; int k;
    for (int i = 0; i < 24; i++) begin
      v = 13'($urandom); sh = 4'($urandom_range(0, 15)); ar = 1'($urandom);
      runOp(v, sh, ar, 1'b0, o, s, lat, bc, bbd);
      k = effAmount(sh);
      nCompared++;
      if (o !== refOut(v, sh, ar) || s !== refSticky(v, sh) || lat !== k + 1 || bc !== k + 1) begin
        nMismatched++;
        $display("[TB] FAIL random[%0d]: in=%h sh=%0d ar=%b got out=%h sticky=%b lat=%0d busy=%0d, expected out=%h sticky=%b lat=%0d",
                 i, v, sh, ar, o, s, lat, bc, refOut(v, sh, ar), refSticky(v, sh), k + 1);
      end
      @(posedge clk); #1;
      nCompared++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.out12 !== o) begin
        nMismatched++;
        $display("[TB] FAIL done_pulse[%0d]: got done=%b busy=%b out=%h, expected 0/0/%h",
                 i, bus.done, bus.busy, bus.out12, o);
      end
    end
  endtask

  task automatic test_start_held();
    logic [12:0] a; logic [12:0] b; logic [12:0] o; logic s; int lat; int bc; bit bbd;
    a = 13'h15A3; b = 13'h0F0F;
    runOp(a, 4'd5, 1'b1, 1'b1, o, s, lat, bc, bbd);
    nCompared++;
    if (o !== refOut(a, 4'd5, 1'b1) || lat !== 6) begin
      nMismatched++;
      $display("[TB] FAIL held_first: got out=%h lat=%0d, expected out=%h lat=6", o, lat, refOut(a, 4'd5, 1'b1));
    end
    bus.in13 = b; bus.shamt = 4'd3; bus.arith = 1'b0;
    @(posedge clk); #1;
    nCompared++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.out12 !== o) begin
      nMismatched++;
      $display("[TB] FAIL held_done_ignored: got busy=%b done=%b out=%h, expected 0/0/%h", bus.busy, bus.done, bus.out12, o);
    end
    runOp(b, 4'd3, 1'b0, 1'b0, o, s, lat, bc, bbd);
    nCompared++;
    if (o !== refOut(b, 4'd3, 1'b0) || lat !== 4) begin
      nMismatched++;
      $display("[TB] FAIL held_second: got out=%h lat=%0d, expected out=%h lat=4", o, lat, refOut(b, 4'd3, 1'b0));
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    logic [12:0] o; logic s; int lat; int bc; bit bbd; bit activity;
    bus.in13 = 13'h1F3C; bus.shamt = 4'd8; bus.arith = 1'b1; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    reset_n = 1'b0;
    @(posedge clk); #1;
    nCompared++;
    if ({bus.out12, bus.busy, bus.done, bus.sticky} !== 16'h0) begin
      nMismatched++;
      $display("[TB] FAIL reset_mid: got out=%h busy=%b done=%b sticky=%b, expected all zero",
               bus.out12, bus.busy, bus.done, bus.sticky);
    end
    reset_n = 1'b1;
    activity = 1'b0;
    for (int n = 0; n < 12; n++) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) activity = 1'b1;
    end
    nCompared++;
    if (activity !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL reset_aborted: got activity=%b, expected 0", activity);
    end
    runOp(13'h1F3C, 4'd2, 1'b0, 1'b0, o, s, lat, bc, bbd);
    nCompared++;
    if (o !== refOut(13'h1F3C, 4'd2, 1'b0) || lat !== 3) begin
      nMismatched++;
      $display("[TB] FAIL reset_fresh_op: got out=%h lat=%0d, expected out=%h lat=3", o, lat, refOut(13'h1F3C, 4'd2, 1'b0));
    end
    @(posedge clk); #1;
  endtask

  task automatic test_idle_hold();
    logic [12:0] held; logic heldSticky; bit bad;
    held = bus.out12; heldSticky = bus.sticky; bad = 1'b0;
    bus.start = 1'b0;
    for (int n = 0; n < 6; n++) begin
      bus.in13 = 13'($urandom); bus.shamt = 4'($urandom); bus.arith = 1'($urandom);
      @(posedge clk); #1;
      if (bus.out12 !== held || bus.sticky !== heldSticky || bus.busy || bus.done) bad = 1'b1;
    end
    nCompared++;
    if (bad !== 1'b0 || held !== refOut(13'h1F3C, 4'd2, 1'b0)) begin
      nMismatched++;
      $display("[TB] FAIL idle_hold: got out=%h, expected %h held with busy=0 done=0",
               bus.out12, refOut(13'h1F3C, 4'd2, 1'b0));
    end
  endtask

  initial begin
    nCompared = 0; nMismatched = 0;
    reset_n = 1'b0; bus.start = 1'b0; bus.in13 = '0; bus.shamt = '0; bus.arith = 1'b0;
    test_reset();
    test_plan_vectors();
    test_random();
    test_start_held();
    test_reset_mid();
    test_idle_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end
endmodule
